// File: rtl/snoop_bus_ctrl.sv
// Snooping bus controller for three caches and main memory: round-robin
// arbitration, snoop broadcast, response collection and memory sequencing.
module snoop_bus_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [5:0]            req_op,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            gnt,
  output logic [1:0]            processador,
  output logic                  bus_valid,
  output logic [1:0]            bus_op,
  output logic [ADDR_W-1:0]     bus_addr,
  input  logic [2:0]            snoop_hit,
  input  logic [2:0]            snoop_dirty,
  input  logic [3*DATA_W-1:0]   snoop_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic [2:0]            done,
  output logic [DATA_W-1:0]     rdata,
  output logic                  shared,
  output logic [2:0]            state_dbg
);

  // Handshakes: req[i] is held by cache i until its one-cycle done[i] pulse;
  // mem_req with mem_we/mem_addr/mem_wdata stays stable until the cycle that
  // sees mem_ack, and the access completes in that cycle.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_BCAST = 3'd2,
    S_SNOOP = 3'd3,
    S_MEM   = 3'd4,
    S_FLUSH = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] OP_RD_MISS = 2'b00;
  localparam logic [1:0] OP_WR_MISS = 2'b01;
  localparam logic [1:0] OP_WB      = 2'b11;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr;
  logic [1:0]          owner;
  logic [1:0]          op_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                we_r;
  logic [DATA_W-1:0]   rdata_r;
  logic                shared_r;

  logic [1:0]          op_a    [3];
  logic [ADDR_W-1:0]   addr_a  [3];
  logic [DATA_W-1:0]   wdata_a [3];
  logic [DATA_W-1:0]   sdata_a [3];

  logic [1:0]          c0, c1, c2, win;
  logic                win_valid;
  logic [2:0]          own_mask, hit_m, dirty_m;
  logic [1:0]          src;
  logic                is_miss;

  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      op_a[i]    = req_op[2*i +: 2];
      addr_a[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_a[i] = req_wdata[i*DATA_W +: DATA_W];
      sdata_a[i] = snoop_data[i*DATA_W +: DATA_W];
    end
  end

  // Scan order starts at rr_ptr so the last owner is checked last.
  always_comb begin
    c0 = rr_ptr;
    c1 = mod3_inc(c0);
    c2 = mod3_inc(c1);
    win_valid = |req;
    if (req[c0])      win = c0;
    else if (req[c1]) win = c1;
    else              win = c2;
  end

  always_comb begin
    own_mask = ~(3'b001 << owner);
    hit_m    = snoop_hit & own_mask;
    dirty_m  = snoop_dirty & own_mask;
    if (dirty_m[0])      src = 2'd0;
    else if (dirty_m[1]) src = 2'd1;
    else                 src = 2'd2;
    is_miss = (op_r == OP_RD_MISS) || (op_r == OP_WR_MISS);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_valid) state_nxt = S_GRANT;
      S_GRANT: state_nxt = S_BCAST;
      S_BCAST: state_nxt = S_SNOOP;
      S_SNOOP: begin
        if (op_r == OP_WB)              state_nxt = S_MEM;
        else if (!is_miss)              state_nxt = S_DONE;
        else if (|dirty_m)              state_nxt = S_FLUSH;
        else                            state_nxt = S_MEM;
      end
      S_MEM:   if (mem_ack) state_nxt = S_DONE;
      S_FLUSH: if (mem_ack) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= 2'd0;
      owner    <= 2'd0;
      op_r     <= 2'd0;
      addr_r   <= '0;
      wdata_r  <= '0;
      we_r     <= 1'b0;
      rdata_r  <= '0;
      shared_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (win_valid) begin
          owner   <= win;
          op_r    <= op_a[win];
          addr_r  <= addr_a[win];
          wdata_r <= wdata_a[win];
        end
        S_SNOOP: begin
          shared_r <= |hit_m;
          we_r     <= (op_r == OP_WB);
          if (is_miss && |dirty_m) rdata_r <= sdata_a[src];
        end
        S_MEM:  if (mem_ack && !we_r) rdata_r <= mem_rdata;
        S_DONE: rr_ptr <= mod3_inc(owner);
        default: ;
      endcase
    end
  end

  // Outputs decode from state, so an asynchronous reset clears them at once.
  always_comb begin
    gnt         = 3'b000;
    processador = 2'd3;
    bus_valid   = 1'b0;
    bus_op      = 2'd0;
    bus_addr    = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    done        = 3'b000;
    if (state != S_IDLE) begin
      gnt         = 3'b001 << owner;
      processador = owner;
      bus_op      = op_r;
      bus_addr    = addr_r;
    end
    bus_valid = (state == S_BCAST);
    if (state == S_MEM) begin
      mem_req  = 1'b1;
      mem_we   = we_r;
      mem_addr = addr_r;
      if (we_r) mem_wdata = wdata_r;
    end
    if (state == S_FLUSH) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = addr_r;
      mem_wdata = rdata_r;
    end
    if (state == S_DONE) done = 3'b001 << owner;
  end

  assign rdata     = rdata_r;
  assign shared    = shared_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Directed bench for snoop_bus_ctrl: scoreboarded completions plus
// cycle-level checks of grant, broadcast and memory sequencing.
module tb_snoop_bus_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [5:0]  req_op;
  logic [11:0] req_addr;
  logic [11:0] req_wdata;
  logic [2:0]  gnt;
  logic [1:0]  processador;
  logic        bus_valid;
  logic [1:0]  bus_op;
  logic [3:0]  bus_addr;
  logic [2:0]  snoop_hit;
  logic [2:0]  snoop_dirty;
  logic [11:0] snoop_data;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata = 4'd0;
  logic        mem_ack = 1'b0;
  logic [2:0]  done;
  logic [3:0]  rdata;
  logic        shared;
  logic [2:0]  state_dbg;

  snoop_bus_ctrl #(.ADDR_W(4), .DATA_W(4)) dut (
    .clock(clock), .reset(reset), .req(req), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .processador(processador), .bus_valid(bus_valid), .bus_op(bus_op),
    .bus_addr(bus_addr), .snoop_hit(snoop_hit), .snoop_dirty(snoop_dirty),
    .snoop_data(snoop_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .done(done), .rdata(rdata), .shared(shared),
    .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Memory model: acks on the ack_delay-th cycle of a request and logs writes.
  int         ack_delay = 1;
  int         wait_cnt = 0;
  int         req_cycles = 0;
  logic       force_ack = 1'b0;
  logic [3:0] mem [16];
  logic [3:0] last_wr_addr = 4'd0;
  logic [3:0] last_wr_data = 4'd0;

  always @(negedge clock) begin
    if (mem_req) begin
      req_cycles++;
      if (wait_cnt + 1 >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr];
        if (mem_we) begin
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
        end
        wait_cnt = 0;
      end else begin
        mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      mem_ack  = force_ack;
      wait_cnt = 0;
    end
  end

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Completion record: {done, rdata, shared}.
  task automatic check_done(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed=%0h expected=<empty queue>", tag, {done, rdata, shared});
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, done, rdata, shared}, {24'd0, e});
    end
  endtask

  task automatic wait_done(input string tag, input int budget, output int cyc);
    cyc = 0;
    while (done == 3'b000 && cyc < budget) begin
      tick();
      cyc++;
    end
    if (done == 3'b000) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed=no done expected=done within %0d cycles", tag, budget);
    end
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=time limit expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int rc0;
    reset = 1'b0;
    req = 3'b000; req_op = 6'd0; req_addr = 12'd0; req_wdata = 12'd0;
    snoop_hit = 3'b000; snoop_dirty = 3'b000; snoop_data = 12'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'(i + 3);
    mem[5] = 4'd9;
    #1;
    chk("rst_processador", processador, 2'd3);
    chk("rst_gnt", gnt, 3'b000);
    chk("rst_outs", {bus_valid, mem_req, done, rdata, shared}, 10'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset while in MEM: outputs clear immediately, no done.
    ack_delay = 10;
    req = 3'b001; req_op = 6'b000000; req_addr = 12'h005;
    tick(); tick(); tick(); tick();
    chk("mid_mem_req", mem_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("rst_async_memreq", mem_req, 1'b0);
    chk("rst_async_gnt", gnt, 3'b000);
    chk("rst_async_proc", processador, 2'd3);
    chk("rst_async_done", done, 3'b000);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("post_rst_gnt", gnt, 3'b001);
    chk("post_rst_proc", processador, 2'd0);
    req = 3'b000;
    do_reset();

    // Read miss from memory; owner's own hit/dirty must be ignored.
    ack_delay = 1;
    snoop_hit = 3'b001; snoop_dirty = 3'b001;
    req = 3'b001; req_op = 6'b000000; req_addr = 12'h005;
    exp_q.push_back({3'b001, 4'd9, 1'b0});
    tick();
    chk("rd_gnt", gnt, 3'b001);
    chk("rd_proc", processador, 2'd0);
    chk("rd_bus_valid_grant", bus_valid, 1'b0);
    chk("rd_bus_addr", bus_addr, 4'd5);
    tick();
    chk("rd_bus_valid", bus_valid, 1'b1);
    chk("rd_bus_op", bus_op, 2'b00);
    tick();
    chk("rd_bus_valid_off", bus_valid, 1'b0);
    req_addr = 12'h002;
    tick();
    chk("rd_mem", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 4'd5});
    wait_done("rd_done_wait", 4, cyc);
    chk("rd_latency", cyc, 1);
    check_done("rd_done");
    req = 3'b000;
    tick();
    chk("rd_idle", {done, gnt, processador}, {3'b000, 3'b000, 2'd3});
    chk("rd_hold", rdata, 4'd9);

    // Read miss served by a dirty peer via FLUSH.
    snoop_hit = 3'b101; snoop_dirty = 3'b100; snoop_data = {4'd6, 4'd2, 4'd2};
    req = 3'b010; req_op = 6'b000000; req_addr = 12'h030;
    exp_q.push_back({3'b010, 4'd6, 1'b1});
    tick(); tick(); tick(); tick();
    chk("fl_gnt", gnt, 3'b010);
    chk("fl_mem", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'd3, 4'd6});
    wait_done("fl_done_wait", 4, cyc);
    check_done("fl_done");
    chk("fl_mem_written", {last_wr_addr, last_wr_data}, {4'd3, 4'd6});
    req = 3'b000;
    tick();

    // Write-back with a slow memory.
    ack_delay = 3;
    snoop_hit = 3'b000; snoop_dirty = 3'b000;
    req = 3'b100; req_op = 6'b110000; req_addr = 12'h700; req_wdata = 12'h400;
    exp_q.push_back({3'b100, 4'd6, 1'b0});
    tick(); tick(); tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wb_mem", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'd7, 4'd4});
      chk("wb_no_done", done, 3'b000);
    end
    wait_done("wb_done_wait", 3, cyc);
    chk("wb_latency", cyc, 1);
    check_done("wb_done");
    chk("wb_mem_written", {last_wr_addr, last_wr_data}, {4'd7, 4'd4});
    req = 3'b000;
    ack_delay = 1;
    do_reset();

    // Three continuous invalidates: round-robin 0,1,2,0; stray mem_ack ignored.
    rc0 = req_cycles;
    force_ack = 1'b1;
    snoop_hit = 3'b111;
    req = 3'b111; req_op = 6'b101010;
    exp_q.push_back({3'b001, 4'd0, 1'b1});
    exp_q.push_back({3'b010, 4'd0, 1'b1});
    exp_q.push_back({3'b100, 4'd0, 1'b1});
    exp_q.push_back({3'b001, 4'd0, 1'b1});
    for (int k = 0; k < 4; k++) begin
      wait_done("inv_done_wait", 8, cyc);
      chk("inv_latency", cyc, 4);
      check_done("inv_done");
      tick();
      chk("inv_gap", {done, gnt}, 6'd0);
    end
    req = 3'b000;
    force_ack = 1'b0;
    tick();
    chk("inv_no_mem", req_cycles - rc0, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
